// File: rtl/johnson_counter_n_if.sv
// Control and status bundle for johnson_counter_n. The bench or host logic
// takes the master side; the counter takes the slave side.
interface johnson_counter_n_if #(
  parameter int WIDTH = 4
);
  localparam int PW = $clog2(2 * WIDTH);

  logic             en;
  logic             dir;
  logic             mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qbar;
  logic [PW-1:0]    phase;
  logic             tc;
  logic             err;

  modport master (
    output en, dir, mode, load, load_val,
    input  Q, Qbar, phase, tc, err
  );

  modport slave (
    input  en, dir, mode, load, load_val,
    output Q, Qbar, phase, tc, err
  );
endinterface

// File: rtl/johnson_counter_n.sv
// Parametrised twisted-ring / one-hot ring phase counter with direction,
// enable, parallel load, illegal-state self-correction and phase decode.
module johnson_counter_n #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  johnson_counter_n_if.slave  bus
);
  localparam int PW = $clog2(2 * WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] next_q;
  logic [WIDTH-1:0] seed;
  logic             mode_q;
  logic             err_q;
  logic             next_err;
  logic [CW-1:0]    ones;
  logic [CW-1:0]    trans;
  logic             legal;
  logic [PW-1:0]    phase;
  logic [PW-1:0]    last_phase;
  logic             wrap_point;

  assign seed = bus.mode ? WIDTH'(1) : '0;

  // Bit population and adjacent-bit transitions classify the state.
  always_comb begin
    ones  = '0;
    trans = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + CW'(q[i]);
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      trans = trans + CW'(q[i] ^ q[i+1]);
    end
  end

  assign legal = bus.mode ? (ones == CW'(1)) : (trans <= CW'(1));

  // NOTE: every variable driven here gets a default on entry, so no path
  // through the if/for nest can leave it unassigned and infer a latch.
  always_comb begin
    phase = '0;
    if (legal) begin
      if (bus.mode) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (q[i]) phase = PW'(i);
        end
      end else if (q[0] || (q == '0)) begin
        phase = PW'(ones);
      end else begin
        phase = PW'(2 * WIDTH) - PW'(ones);
      end
    end
  end

  assign last_phase = bus.mode ? PW'(WIDTH - 1) : PW'(2 * WIDTH - 1);
  assign wrap_point = bus.dir ? (phase == '0) : (phase == last_phase);

  always_comb begin
    next_q   = q;
    next_err = 1'b0;
    if (bus.mode != mode_q) begin
      next_q = seed;
    end else if (bus.load) begin
      next_q = bus.load_val;
    end else if (!legal) begin
      next_q   = seed;
      next_err = 1'b1;
    end else if (bus.en) begin
      unique case ({bus.mode, bus.dir})
        2'b00:   next_q = {q[WIDTH-2:0], ~q[WIDTH-1]};
        2'b01:   next_q = {~q[0], q[WIDTH-1:1]};
        2'b10:   next_q = {q[WIDTH-2:0], q[WIDTH-1]};
        default: next_q = {q[0], q[WIDTH-1:1]};
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= seed;
      err_q <= 1'b0;
    end else begin
      q     <= next_q;
      err_q <= next_err;
    end
  end

  // mode_q follows mode even through reset so a mode chosen during reset
  // is not seen as a change once reset drops.
  always_ff @(posedge clk) begin
    mode_q <= bus.mode;
  end

  assign bus.Q     = q;
  assign bus.Qbar  = ~q;
  assign bus.phase = phase;
  assign bus.err   = err_q;
  assign bus.tc    = !rst && bus.en && legal && !bus.load &&
                     (bus.mode == mode_q) && wrap_point;
endmodule

// File: tb/tb_johnson_counter_n.sv
// Scoreboard bench for johnson_counter_n: a 4-bit instance for the main
// sequences and a 5-bit instance for the wider Johnson and ring cycles.
module tb_johnson_counter_n;
  logic clk = 1'b0;
  logic rst;
  logic rst5;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  johnson_counter_n_if #(.WIDTH(4)) if4 ();
  johnson_counter_n_if #(.WIDTH(5)) if5 ();

  johnson_counter_n #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst),  .bus(if4.slave));
  johnson_counter_n #(.WIDTH(5)) dut5 (.clk(clk), .rst(rst5), .bus(if5.slave));

  typedef struct {
    logic       rst, en, dir, mode, load;
    logic [3:0] lv;
    logic [3:0] q;
    logic [2:0] ph;
    logic       tc, err;
  } step_t;

  typedef struct {
    logic [4:0] q;
    logic [3:0] ph;
    logic       tc;
  } exp5_t;

  step_t sb[$];
  exp5_t sb5[$];

  function automatic step_t mk(input logic r, input logic e, input logic d,
                               input logic m, input logic l, input logic [3:0] lv,
                               input logic [3:0] q, input logic [2:0] ph,
                               input logic tc, input logic err);
    step_t s;
    s.rst = r; s.en = e; s.dir = d; s.mode = m; s.load = l; s.lv = lv;
    s.q = q; s.ph = ph; s.tc = tc; s.err = err;
    return s;
  endfunction

  function automatic logic [4:0] jexp5(input int k);
    if (k <= 5) return 5'((1 << k) - 1);
    return 5'(~((1 << (k - 5)) - 1));
  endfunction

  // Applies one cycle of stimulus and records what the counter must show.
  task automatic drive(input step_t s);
    rst          = s.rst;
    if4.en       = s.en;
    if4.dir      = s.dir;
    if4.mode     = s.mode;
    if4.load     = s.load;
    if4.load_val = s.lv;
    sb.push_back(s);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; if4.en = 1'b0; if4.dir = 1'b1; if4.mode = 1'b1;
    if4.load = 1'b0; if4.load_val = '0;
    @(posedge clk); #1;
    checks++;
    if (if4.Q !== 4'b0001) begin
      errors++; $display("FAIL reset_ring_seed: Q=%b want 0001", if4.Q);
    end
    @(negedge clk);
    if4.mode = 1'b0; if4.en = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (if4.Q !== 4'b0000 || if4.Qbar !== 4'b1111 || if4.err !== 1'b0 || if4.phase !== 3'd0) begin
      errors++;
      $display("FAIL reset_johnson_seed: Q=%b Qbar=%b err=%b phase=%0d want 0000 1111 0 0",
               if4.Q, if4.Qbar, if4.err, if4.phase);
    end
    @(negedge clk);
    if4.dir = 1'b1;
    #1;
    checks++;
    if (if4.tc !== 1'b0) begin
      errors++; $display("FAIL reset_tc_gated: tc=%b want 0", if4.tc);
    end
  endtask

  task automatic test_forward();
    step_t t[$];
    step_t e;
    t.push_back(mk(0,1,0,0,0,4'h0, 4'b0000,3'd0,0,0));
    t.push_back(mk(0,1,0,0,0,4'h0, 4'b0001,3'd1,0,0));
    t.push_back(mk(0,1,0,0,0,4'h0, 4'b0011,3'd2,0,0));
    t.push_back(mk(0,1,0,0,0,4'h0, 4'b0111,3'd3,0,0));
    t.push_back(mk(0,1,0,0,0,4'h0, 4'b1111,3'd4,0,0));
    t.push_back(mk(0,1,0,0,0,4'h0, 4'b1110,3'd5,0,0));
    t.push_back(mk(0,1,0,0,0,4'h0, 4'b1100,3'd6,0,0));
    t.push_back(mk(0,1,0,0,0,4'h0, 4'b1000,3'd7,1,0));
    t.push_back(mk(0,0,0,0,0,4'h0, 4'b0000,3'd0,0,0));
    foreach (t[i]) begin
      @(negedge clk);
      drive(t[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if (if4.Q !== e.q || if4.Qbar !== ~e.q || if4.phase !== e.ph || if4.tc !== e.tc || if4.err !== e.err) begin
        errors++;
        $display("FAIL forward[%0d]: Q=%b Qbar=%b phase=%0d tc=%b err=%b want Q=%b phase=%0d tc=%b err=%b",
                 i, if4.Q, if4.Qbar, if4.phase, if4.tc, if4.err, e.q, e.ph, e.tc, e.err);
      end
    end
  endtask

  task automatic test_reverse();
    step_t t[$];
    step_t e;
    t.push_back(mk(0,1,1,0,0,4'h0, 4'b0000,3'd0,1,0));
    t.push_back(mk(0,1,1,0,0,4'h0, 4'b1000,3'd7,0,0));
    t.push_back(mk(0,1,1,0,0,4'h0, 4'b1100,3'd6,0,0));
    t.push_back(mk(0,1,1,0,0,4'h0, 4'b1110,3'd5,0,0));
    t.push_back(mk(0,1,1,0,0,4'h0, 4'b1111,3'd4,0,0));
    t.push_back(mk(0,1,1,0,0,4'h0, 4'b0111,3'd3,0,0));
    t.push_back(mk(0,1,1,0,0,4'h0, 4'b0011,3'd2,0,0));
    t.push_back(mk(0,1,1,0,0,4'h0, 4'b0001,3'd1,0,0));
    t.push_back(mk(0,1,1,0,0,4'h0, 4'b0000,3'd0,1,0));
    t.push_back(mk(0,0,1,0,0,4'h0, 4'b1000,3'd7,0,0));
    foreach (t[i]) begin
      @(negedge clk);
      drive(t[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if (if4.Q !== e.q || if4.Qbar !== ~e.q || if4.phase !== e.ph || if4.tc !== e.tc || if4.err !== e.err) begin
        errors++;
        $display("FAIL reverse[%0d]: Q=%b Qbar=%b phase=%0d tc=%b err=%b want Q=%b phase=%0d tc=%b err=%b",
                 i, if4.Q, if4.Qbar, if4.phase, if4.tc, if4.err, e.q, e.ph, e.tc, e.err);
      end
    end
  endtask

  task automatic test_mode_switch();
    step_t t[$];
    step_t e;
    t.push_back(mk(1,0,0,0,0,4'h0, 4'b1000,3'd7,0,0));
    t.push_back(mk(0,1,0,0,0,4'h0, 4'b0000,3'd0,0,0));
    t.push_back(mk(0,1,0,0,0,4'h0, 4'b0001,3'd1,0,0));
    t.push_back(mk(0,1,0,0,0,4'h0, 4'b0011,3'd2,0,0));
    t.push_back(mk(0,1,0,1,0,4'h0, 4'b0111,3'd0,0,0));
    t.push_back(mk(0,1,0,1,0,4'h0, 4'b0001,3'd0,0,0));
    t.push_back(mk(0,1,0,1,0,4'h0, 4'b0010,3'd1,0,0));
    t.push_back(mk(0,1,0,1,0,4'h0, 4'b0100,3'd2,0,0));
    t.push_back(mk(0,1,0,1,0,4'h0, 4'b1000,3'd3,1,0));
    t.push_back(mk(0,0,0,1,0,4'h0, 4'b0001,3'd0,0,0));
    foreach (t[i]) begin
      @(negedge clk);
      drive(t[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if (if4.Q !== e.q || if4.Qbar !== ~e.q || if4.phase !== e.ph || if4.tc !== e.tc || if4.err !== e.err) begin
        errors++;
        $display("FAIL mode_switch[%0d]: Q=%b Qbar=%b phase=%0d tc=%b err=%b want Q=%b phase=%0d tc=%b err=%b",
                 i, if4.Q, if4.Qbar, if4.phase, if4.tc, if4.err, e.q, e.ph, e.tc, e.err);
      end
    end
  endtask

  task automatic test_illegal();
    step_t t[$];
    step_t e;
    t.push_back(mk(0,0,0,0,0,4'h0, 4'b0001,3'd1,0,0));
    t.push_back(mk(0,1,0,0,1,4'h5, 4'b0000,3'd0,0,0));
    t.push_back(mk(0,1,0,0,0,4'h0, 4'b0101,3'd0,0,0));
    t.push_back(mk(0,1,0,0,0,4'h0, 4'b0000,3'd0,0,1));
    t.push_back(mk(0,0,0,0,0,4'h0, 4'b0001,3'd1,0,0));
    t.push_back(mk(0,0,0,0,1,4'h5, 4'b0001,3'd1,0,0));
    t.push_back(mk(0,0,0,0,0,4'h0, 4'b0101,3'd0,0,0));
    t.push_back(mk(0,0,0,0,0,4'h0, 4'b0000,3'd0,0,1));
    t.push_back(mk(0,0,0,0,0,4'h0, 4'b0000,3'd0,0,0));
    foreach (t[i]) begin
      @(negedge clk);
      drive(t[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if (if4.Q !== e.q || if4.Qbar !== ~e.q || if4.phase !== e.ph || if4.tc !== e.tc || if4.err !== e.err) begin
        errors++;
        $display("FAIL illegal[%0d]: Q=%b Qbar=%b phase=%0d tc=%b err=%b want Q=%b phase=%0d tc=%b err=%b",
                 i, if4.Q, if4.Qbar, if4.phase, if4.tc, if4.err, e.q, e.ph, e.tc, e.err);
      end
    end
  endtask

  task automatic test_rst_priority();
    step_t t[$];
    step_t e;
    t.push_back(mk(0,1,0,0,0,4'h0, 4'b0000,3'd0,0,0));
    t.push_back(mk(0,1,0,0,0,4'h0, 4'b0001,3'd1,0,0));
    t.push_back(mk(0,1,0,0,0,4'h0, 4'b0011,3'd2,0,0));
    t.push_back(mk(1,1,0,0,1,4'h3, 4'b0111,3'd3,0,0));
    for (int k = 0; k < 5; k++) t.push_back(mk(0,0,0,0,0,4'h0, 4'b0000,3'd0,0,0));
    foreach (t[i]) begin
      @(negedge clk);
      drive(t[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if (if4.Q !== e.q || if4.Qbar !== ~e.q || if4.phase !== e.ph || if4.tc !== e.tc || if4.err !== e.err) begin
        errors++;
        $display("FAIL rst_priority[%0d]: Q=%b Qbar=%b phase=%0d tc=%b err=%b want Q=%b phase=%0d tc=%b err=%b",
                 i, if4.Q, if4.Qbar, if4.phase, if4.tc, if4.err, e.q, e.ph, e.tc, e.err);
      end
    end
  endtask

  task automatic test_width5();
    exp5_t e;
    for (int m = 0; m < 2; m++) begin
      int period;
      period = (m == 0) ? 10 : 5;
      @(negedge clk);
      rst5 = 1'b1; if5.mode = (m == 1); if5.en = 1'b0; if5.dir = 1'b0;
      if5.load = 1'b0; if5.load_val = '0;
      @(negedge clk);
      rst5 = 1'b0; if5.en = 1'b1;
      for (int k = 0; k <= period; k++) begin
        int p;
        if (k > 0) @(negedge clk);
        p = k % period;
        e.q  = (m == 0) ? jexp5(p) : 5'(1 << p);
        e.ph = 4'(p);
        e.tc = (p == period - 1);
        sb5.push_back(e);
        #1;
        e = sb5.pop_front();
        checks++;
        if (if5.Q !== e.q || if5.Qbar !== ~e.q || if5.phase !== e.ph || if5.tc !== e.tc || if5.err !== 1'b0) begin
          errors++;
          $display("FAIL width5_%s[%0d]: Q=%b phase=%0d tc=%b err=%b want Q=%b phase=%0d tc=%b err=0",
                   (m == 0) ? "johnson" : "ring", k, if5.Q, if5.phase, if5.tc, if5.err, e.q, e.ph, e.tc);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; rst5 = 1'b1;
    if4.en = 1'b0; if4.dir = 1'b0; if4.mode = 1'b0; if4.load = 1'b0; if4.load_val = '0;
    if5.en = 1'b0; if5.dir = 1'b0; if5.mode = 1'b0; if5.load = 1'b0; if5.load_val = '0;
    test_reset();
    test_forward();
    test_reverse();
    test_mode_switch();
    test_illegal();
    test_rst_priority();
    test_width5();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/johnson_counter_n.md
Name: johnson_counter_n

Overview:
Parametrised shift-register phase counter, the generalised successor to the fixed 4-bit Johnson counter.
- Width is set by parameter; Johnson (twisted-ring) or plain ring (one-hot) mode is selected at run time.
- Supports up/down direction, count enable, parallel load and illegal-state self-correction.
- Provides a decoded phase index and a terminal-count strobe.
- Used as a multi-phase sequencer and clock-phase generator in FPGA lab designs.

Parameters:
WIDTH, 4, number of state flip-flops (legal range 2..16).
PW, $clog2(2*WIDTH), width of the phase output (derived; not overridden).

Ports:
clk  input  1  system clock, rising-edge active.
rst  input  1  synchronous active-high reset.
en  input  1  count enable; the state advances one step per cycle while high.
dir  input  1  0 = forward (shift toward MSB, feedback into Q[0]); 1 = reverse (shift toward LSB, feedback into Q[WIDTH-1]).
mode  input  1  0 = Johnson (2*WIDTH states); 1 = ring (WIDTH states).
load  input  1  parallel-load strobe.
load_val  input  WIDTH  value written to Q on load.
Q  output  WIDTH  registered counter state.
Qbar  output  WIDTH  always equal to ~Q.
phase  output  PW  decoded state index (combinational from Q and mode).
tc  output  1  terminal-count strobe (combinational).
err  output  1  registered; high for one cycle after an illegal-state correction.

Behaviour:
- Seed value: all zeros in Johnson mode; 0...01 in ring mode.
- mode_q register: captures mode every cycle, including during rst.
- Next-state priority, highest first:
  1. rst: Q <= seed(mode), err <= 0.
  2. mode != mode_q: Q <= seed(mode). The mode change is applied 1 cycle late; the in-flight state is discarded.
  3. load: Q <= load_val, accepted unconditionally (even if illegal); en is ignored this cycle.
  4. Q illegal for the current mode: Q <= seed(mode), err <= 1. This happens regardless of en.
  5. en high:
     - Johnson forward: Q <= {Q[W-2:0], ~Q[W-1]}.
     - Johnson reverse: Q <= {~Q[0], Q[W-1:1]}.
     - Ring forward: Q <= {Q[W-2:0], Q[W-1]}.
     - Ring reverse: Q <= {Q[0], Q[W-1:1]}.
  6. Otherwise: hold.
- err is 0 in every cycle that does not follow a correcting edge.
- Legal states:
  - Johnson: at most one i in 0..W-2 with Q[i] != Q[i+1].
  - Ring: exactly one bit set.
- Phase decode:
  - Johnson: if Q[0]==1 or Q==0, phase = popcount(Q); else phase = 2W - popcount(Q).
  - Ring: phase = index of the set bit.
  - Illegal state: phase = 0.
- Phase sequence: the forward sequence increments phase by 1 mod P, where P = 2W (Johnson) or W (ring). Reverse decrements it.
- tc = en & legal & ~load & (mode==mode_q) & ((dir==0 & phase==P-1) | (dir==1 & phase==0)). It marks the cycle whose edge wraps the phase.
- Reset values: Q = seed of the mode sampled during rst; Qbar = ~seed; err = 0; phase = 0; tc = 0 while rst is high (gated).
- Direction change mid-count takes effect on the next enabled edge, with no glitch or skip.
- Reset asserted mid-load or mid-count: rst wins in that cycle.

Test Plan:
1. WIDTH=4, mode=0, rst 1 cycle, then en=1, dir=0 -> Q = 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000. Phase runs 0..7 then 0; tc high only while Q=1000; Qbar = ~Q every cycle.
2. From Q=0000, dir=1, en=1 -> Q = 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000. Phase runs 7..0; tc high while Q=0000 (before the first step) and again at the final 0000.
3. Count to Q=0111, then set mode=1 -> Q=0001 on the next edge with tc=0 in that cycle; then 0010, 0100, 1000, 0001. tc high at Q=1000; phase runs 0..3.
4. mode=0, load=1 with load_val=0101 -> Q=0101 and phase=0 for one cycle; next edge Q=0000 and err=1 for exactly one cycle. Repeat with en=0: correction still occurs.
5. Simultaneous rst=1, load=1 (load_val=0011), en=1 at Q=0111 -> Q=0000, err=0. With en=0 and no load for 5 cycles, Q holds and tc=0.
6. WIDTH=5, mode=0 forward -> a 10-state cycle with phase 0..9 and PW=4. WIDTH=5 ring -> a 5-state cycle, 00001 to 10000.
